// File: rtl/ir_prefetch_if.sv
// ir_prefetch_if: bundles the fetch-side (MBOX) and IR-side signals of the
// instruction prefetch queue.
//   master : view used by ir_prefetch (drives fetch_req/fetch_vma and the IR head)
//   slave  : view used by the EBOX/MBOX side (drives control, ack, data, load_ir)
// Signals:
//   fetch_en, flush, flush_vma        control from EBOX
//   fetch_req, fetch_vma              request to MBOX
//   fetch_ack, cache_data             MBOX acceptance and returned word
//   load_ir                           IR consumes head entry
//   ir_valid, ir_word, ir_pc          head entry presented to IR
// Optional (IR_PREFETCH_PAR_EN defined): cache_par in, ir_par_err out.
interface ir_prefetch_if #(
   parameter int unsigned VMA_WIDTH = 23
);
   logic                   fetch_en;
   logic                   flush;
   logic [36-VMA_WIDTH:35] flush_vma;
   logic                   fetch_req;
   logic [36-VMA_WIDTH:35] fetch_vma;
   logic                   fetch_ack;
   logic [0:35]            cache_data;
   logic                   load_ir;
   logic                   ir_valid;
   logic [0:35]            ir_word;
   logic [36-VMA_WIDTH:35] ir_pc;
`ifdef IR_PREFETCH_PAR_EN
   logic                   cache_par;
   logic                   ir_par_err;
`endif

   modport master (
      input  fetch_en, flush, flush_vma, fetch_ack, cache_data, load_ir,
`ifdef IR_PREFETCH_PAR_EN
      input  cache_par,
      output ir_par_err,
`endif
      output fetch_req, fetch_vma, ir_valid, ir_word, ir_pc
   );

   modport slave (
      output fetch_en, flush, flush_vma, fetch_ack, cache_data, load_ir,
`ifdef IR_PREFETCH_PAR_EN
      output cache_par,
      input  ir_par_err,
`endif
      input  fetch_req, fetch_vma, ir_valid, ir_word, ir_pc
   );
endinterface

// File: rtl/ir_prefetch.sv
// ir_prefetch: instruction prefetch queue feeding the IR stage. Issues one
// sequential fetch at a time to the MBOX cache, buffers returned 36-bit words
// with their PCs, presents the head to IR; load_ir pops it, flush redirects.
// Ports:
//   clk    EBOX clock
//   reset  synchronous, active-high
//   bus    ir_prefetch_if.master (fetch handshake, IR head, control)
//   count  occupied entries
// Option macro IR_PREFETCH_PAR_EN: stores odd parity per entry and reports
// ir_par_err for a bad head entry.
module ir_prefetch #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned VMA_WIDTH = 23
) (
   input  logic                       clk,
   input  logic                       reset,
   ir_prefetch_if.master              bus,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int unsigned CntW  = $clog2(DEPTH + 1);
   localparam int unsigned PtrW  = $clog2(DEPTH);
   localparam int unsigned VmaLo = 36 - VMA_WIDTH;

   typedef logic [VmaLo:35] vma_t;
   typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_t;

   state_t          state_q, state_d;
   vma_t            next_vma_q, next_vma_d;
   vma_t            fetch_vma_q, fetch_vma_d;
   logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CntW-1:0] count_q, count_d;
   logic [0:35]     word_q [DEPTH];
   vma_t            pc_q   [DEPTH];
`ifdef IR_PREFETCH_PAR_EN
   logic [DEPTH-1:0] par_q;
`endif
   logic            push, pop;

   always_comb begin
      state_d     = state_q;
      next_vma_d  = next_vma_q;
      fetch_vma_d = fetch_vma_q;
      push        = 1'b0;
      pop         = bus.load_ir && (count_q != '0);

      case (state_q)
         StIdle: begin
            // Requesting only with a free slot reserves it for the returning word.
            if (bus.fetch_en && (count_q < CntW'(DEPTH))) begin
               state_d     = StReq;
               fetch_vma_d = next_vma_q;
            end
         end
         StReq: begin
            if (bus.fetch_ack) begin
               push              = 1'b1;
               // Only the in-section part advances; section bits are preserved.
               next_vma_d[18:35] = next_vma_q[18:35] + 18'd1;
               state_d           = StIdle;
            end
         end
         StDiscard: begin
            if (bus.fetch_ack) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (bus.flush) begin
         // Flush wins over ack and pop; an in-flight request must still complete.
         push        = 1'b0;
         pop         = 1'b0;
         next_vma_d  = bus.flush_vma;
         fetch_vma_d = fetch_vma_q;
         state_d     = (state_q == StIdle || bus.fetch_ack) ? StIdle : StDiscard;
         count_d     = '0;
         head_d      = '0;
         tail_d      = '0;
      end else begin
         count_d = count_q + CntW'(push) - CntW'(pop);
         head_d  = head_q + PtrW'(pop);
         tail_d  = tail_q + PtrW'(push);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         next_vma_q  <= '0;
         fetch_vma_q <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            word_q[i] <= '0;
            pc_q[i]   <= '0;
         end
`ifdef IR_PREFETCH_PAR_EN
         par_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         next_vma_q  <= next_vma_d;
         fetch_vma_q <= fetch_vma_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         if (push) begin
            word_q[tail_q] <= bus.cache_data;
            pc_q[tail_q]   <= fetch_vma_q;
`ifdef IR_PREFETCH_PAR_EN
            par_q[tail_q]  <= bus.cache_par;
`endif
         end
      end
   end

   // Reset removes the request in the same cycle rather than at the next edge.
   assign bus.fetch_req = (state_q != StIdle) && !reset;
   assign bus.fetch_vma = fetch_vma_q;
   assign bus.ir_valid  = (count_q != '0);
   assign bus.ir_word   = word_q[head_q];
   assign bus.ir_pc     = pc_q[head_q];
   assign count         = count_q;
`ifdef IR_PREFETCH_PAR_EN
   // Odd parity: data plus parity bit must hold an odd number of ones.
   assign bus.ir_par_err = bus.ir_valid && !(^{word_q[head_q], par_q[head_q]});
`endif
endmodule
